aes_job_scheduler: RTL and testbench
====================================

# aes_job_scheduler

Descriptor-queue sequencer for the AES-CTR streaming datapath. Accepts job descriptors (source/destination line address, byte length, 128-bit IV) from the CSR layer. Holds them in a small FIFO and launches one job at a time: a single-cycle run pulse plus stable job parameters go to the read mover, the write mover and the IV/counter loader. Tracks both mover completions, a watchdog, and status counters so software can queue work without polling per job.

## Interface
- QUEUE_DEPTH, 4, descriptor FIFO entries (power of two, ≥2)
- ADDR_W, 58, cache-line address width
- TIMEOUT, 0, max cycles in WAIT before abort; 0 disables the watchdog
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- desc_valid  in  1  descriptor offered
- desc_ready  out  1  descriptor accepted when valid&&ready
- desc_src_cl  in  ADDR_W  source line address
- desc_dest_cl  in  ADDR_W  destination line address
- desc_length  in  64  byte length
- desc_iv  in  128  initial counter block
- flush  in  1  drop all queued (not in-flight) descriptors
- clr_err  in  1  clear sticky error flags
- job_run  out  1  one-cycle launch pulse
- job_src_cl / job_dest_cl  out  ADDR_W  current job addresses
- job_length  out  64  current job length
- job_iv  out  128  current job IV
- rd_done  in  1  read mover done (level)
- wr_done  in  1  write mover done (level)
- busy  out  1  job in flight (state ≠ IDLE)
- queue_count  out  $clog2(QUEUE_DEPTH)+1  queued descriptors
- jobs_done  out  32  completed-job counter, wraps
- err_len  out  1  sticky: descriptor rejected
- err_timeout  out  1  sticky: watchdog fired

## Operation
- Reset (reset=0, async): state IDLE; FIFO empty; all outputs 0 except desc_ready=1; job_* registers 0.
- desc_ready = !full && !flush.
- Accepted descriptor with length==0 or length[5:0]≠0 is not enqueued and sets err_len.
- States:
  - IDLE: if queue_count≠0, go to LAUNCH.
  - LAUNCH: pop the head into the job_* registers; job_run=1 this cycle only; clear the rd/wr seen latches; go to GUARD.
  - GUARD: one cycle in which done inputs are ignored, because the movers' done levels from the previous job may still be high; go to WAIT.
  - WAIT: latch rd_seen on rd_done and wr_seen on wr_done; when both are set (including the same cycle), go to COMPLETE. If TIMEOUT≠0 and the wait counter reaches TIMEOUT, set err_timeout and go to IDLE without incrementing jobs_done.
  - COMPLETE: jobs_done+1 (wraps at 2^32). Go to LAUNCH if the queue is non-empty, else IDLE.
- job_* outputs hold from the LAUNCH cycle until the next LAUNCH.
- Wait counter: 32 bits, cleared in LAUNCH, increments in GUARD and WAIT.
- flush: empties the FIFO in the same cycle. The in-flight job is unaffected. An enqueue in the same cycle is refused (ready=0). A pop in the same cycle (LAUNCH) still captures the head.
- Simultaneous enqueue and pop: count unchanged. Enqueue is legal when full only if a pop occurs that cycle? No: ready is based on registered full, so no enqueue when full.
- clr_err clears both sticky flags. An error event in the same cycle wins (flag stays 1).

## Timing
- Descriptor accepted at edge N into an empty queue with IDLE: IDLE seen in cycle N+1, job_run high in cycle N+2, job_* valid in N+2.
- Completion: both dones observed in WAIT at cycle M, COMPLETE at M+1, jobs_done updated at edge ending M+1. Next job_run at M+2 if the queue is non-empty.
- Minimum launch-to-launch spacing is 4 cycles (LAUNCH, GUARD, WAIT, COMPLETE).
- queue_count updates on the edge of enqueue/pop/flush.
- Reset mid-job: everything returns to reset values immediately, and job_run does not pulse until a new descriptor arrives after reset release.

## Test plan
- Single job: enqueue len=0x1000, iv=0x1; expect job_run at N+2 with job_length=0x1000; assert rd_done at +10 and wr_done at +20; expect jobs_done=1, busy=0, queue_count=0.
- Back-to-back: enqueue 4 descriptors (fills FIFO; fifth is held with desc_ready=0); dones immediate; expect 4 launches spaced exactly 4 cycles apart, in order; jobs_done=4.
- Stale done: hold rd_done=wr_done=1 continuously; expect each job spends exactly 1 cycle in WAIT (GUARD masks it), never zero.
- Bad length: enqueue len=0 and len=0x41; expect no job_run, err_len=1, queue_count=0; clr_err → err_len=0.
- Watchdog: TIMEOUT=100, never assert wr_done; expect err_timeout=1 at wait count 100, return to IDLE, jobs_done unchanged, next queued job launches.
- Flush/reset: queue 3, flush during first job's WAIT → queue_count=0, first job completes, jobs_done=1; reset asserted mid-WAIT → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/aes_job_scheduler.sv
// Descriptor FIFO plus single-job launch sequencer for the AES-CTR streaming datapath.
// Launches one job at a time, waits for both mover completions and counts finished jobs.
module aes_job_scheduler #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned ADDR_W      = 58,
    parameter int unsigned TIMEOUT     = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           desc_valid_i,
    output logic                           desc_ready_o,
    input  logic [ADDR_W-1:0]              desc_src_cl_i,
    input  logic [ADDR_W-1:0]              desc_dest_cl_i,
    input  logic [63:0]                    desc_length_i,
    input  logic [127:0]                   desc_iv_i,
    input  logic                           flush_i,
    input  logic                           clr_err_i,
    output logic                           job_run_o,
    output logic [ADDR_W-1:0]              job_src_cl_o,
    output logic [ADDR_W-1:0]              job_dest_cl_o,
    output logic [63:0]                    job_length_o,
    output logic [127:0]                   job_iv_o,
    input  logic                           rd_done_i,
    input  logic                           wr_done_i,
    output logic                           busy_o,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count_o,
    output logic [31:0]                    jobs_done_o,
    output logic                           err_len_o,
    output logic                           err_timeout_o
);
    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [2:0] {StIdle, StLaunch, StGuard, StWait, StComplete} state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [31:0]         wait_cnt_q, wait_cnt_d;
    logic [31:0]         jobs_done_q, jobs_done_d;
    logic                rd_seen_q, rd_seen_d, wr_seen_q, wr_seen_d;
    logic                err_len_q, err_len_d, err_to_q, err_to_d;
    logic [ADDR_W-1:0]   job_src_q, job_dest_q;
    logic [63:0]         job_len_q;
    logic [127:0]        job_iv_q;

    logic [ADDR_W-1:0]   src_mem_q  [QUEUE_DEPTH];
    logic [ADDR_W-1:0]   dest_mem_q [QUEUE_DEPTH];
    logic [63:0]         len_mem_q  [QUEUE_DEPTH];
    logic [127:0]        iv_mem_q   [QUEUE_DEPTH];

    logic accept, len_bad, push, pop, timeout_evt, both_done, timeout_hit;

    assign desc_ready_o = (count_q != CntW'(QUEUE_DEPTH)) && !flush_i;
    assign accept       = desc_valid_i && desc_ready_o;
    // Lengths must be a non-zero whole number of 64-byte lines.
    assign len_bad      = (desc_length_i == 64'd0) || (desc_length_i[5:0] != 6'd0);
    assign push         = accept && !len_bad;
    assign both_done    = (rd_seen_q || rd_done_i) && (wr_seen_q || wr_done_i);
    assign timeout_hit  = (TIMEOUT != 0) && (wait_cnt_q >= 32'(TIMEOUT));

    // The head is popped on the edge entering StLaunch so job_* are valid during the pulse.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        timeout_evt = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d = StLaunch;
                    pop     = 1'b1;
                end
            end
            StLaunch: state_d = StGuard;
            StGuard:  state_d = StWait;
            StWait: begin
                if (both_done) begin
                    state_d = StComplete;
                end else if (timeout_hit) begin
                    state_d     = StIdle;
                    timeout_evt = 1'b1;
                end
            end
            StComplete: begin
                if (count_q != '0) begin
                    state_d = StLaunch;
                    pop     = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d    = flush_i ? wr_ptr_q : (pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q);
        count_d     = flush_i ? '0 : count_q + CntW'(push) - CntW'(pop);
        rd_seen_d   = rd_seen_q;
        wr_seen_d   = wr_seen_q;
        wait_cnt_d  = wait_cnt_q;
        if (state_q == StLaunch) begin
            rd_seen_d  = 1'b0;
            wr_seen_d  = 1'b0;
            wait_cnt_d = '0;
        end else if (state_q == StGuard) begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end else if (state_q == StWait) begin
            rd_seen_d  = rd_seen_q || rd_done_i;
            wr_seen_d  = wr_seen_q || wr_done_i;
            wait_cnt_d = wait_cnt_q + 32'd1;
        end
        jobs_done_d = jobs_done_q + ((state_q == StComplete) ? 32'd1 : 32'd0);
        err_len_d   = (accept && len_bad) || (err_len_q && !clr_err_i);
        err_to_d    = timeout_evt || (err_to_q && !clr_err_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wait_cnt_q  <= '0;
            jobs_done_q <= '0;
            rd_seen_q   <= 1'b0;
            wr_seen_q   <= 1'b0;
            err_len_q   <= 1'b0;
            err_to_q    <= 1'b0;
            job_src_q   <= '0;
            job_dest_q  <= '0;
            job_len_q   <= '0;
            job_iv_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wait_cnt_q  <= wait_cnt_d;
            jobs_done_q <= jobs_done_d;
            rd_seen_q   <= rd_seen_d;
            wr_seen_q   <= wr_seen_d;
            err_len_q   <= err_len_d;
            err_to_q    <= err_to_d;
            if (pop) begin
                job_src_q  <= src_mem_q[rd_ptr_q];
                job_dest_q <= dest_mem_q[rd_ptr_q];
                job_len_q  <= len_mem_q[rd_ptr_q];
                job_iv_q   <= iv_mem_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            src_mem_q[wr_ptr_q]  <= desc_src_cl_i;
            dest_mem_q[wr_ptr_q] <= desc_dest_cl_i;
            len_mem_q[wr_ptr_q]  <= desc_length_i;
            iv_mem_q[wr_ptr_q]   <= desc_iv_i;
        end
    end

    assign job_run_o     = (state_q == StLaunch);
    assign busy_o        = (state_q != StIdle);
    assign job_src_cl_o  = job_src_q;
    assign job_dest_cl_o = job_dest_q;
    assign job_length_o  = job_len_q;
    assign job_iv_o      = job_iv_q;
    assign queue_count_o = count_q;
    assign jobs_done_o   = jobs_done_q;
    assign err_len_o     = err_len_q;
    assign err_timeout_o = err_to_q;
endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed bench for aes_job_scheduler: table of single-descriptor cases plus
// hand-written sequences for back-to-back, watchdog, flush and reset.
module tb_aes_job_scheduler;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         desc_valid, desc_ready, flush, clr_err, rd_done, wr_done;
    logic [57:0]  desc_src, desc_dest, job_src, job_dest;
    logic [63:0]  desc_length, job_length;
    logic [127:0] desc_iv, job_iv;
    logic         job_run, busy, err_len, err_timeout;
    logic [2:0]   queue_count;
    logic [31:0]  jobs_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_job_scheduler #(.QUEUE_DEPTH(4), .ADDR_W(58), .TIMEOUT(100)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .desc_valid_i(desc_valid), .desc_ready_o(desc_ready),
        .desc_src_cl_i(desc_src), .desc_dest_cl_i(desc_dest),
        .desc_length_i(desc_length), .desc_iv_i(desc_iv),
        .flush_i(flush), .clr_err_i(clr_err),
        .job_run_o(job_run), .job_src_cl_o(job_src), .job_dest_cl_o(job_dest),
        .job_length_o(job_length), .job_iv_o(job_iv),
        .rd_done_i(rd_done), .wr_done_i(wr_done), .busy_o(busy),
        .queue_count_o(queue_count), .jobs_done_o(jobs_done),
        .err_len_o(err_len), .err_timeout_o(err_timeout)
    );

    typedef struct {
        logic [63:0] len;
        logic        exp_err;
        logic        exp_launch;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [63:0] len, input logic [127:0] iv);
        desc_valid  = 1'b1;
        desc_length = len;
        desc_iv     = iv;
        desc_src    = iv[57:0] + 58'd1;
        desc_dest   = iv[57:0] + 58'd2;
        #1;
        check("enq_ready", {127'd0, desc_ready}, 128'd1);
        step();
        desc_valid = 1'b0;
    endtask

    task automatic wait_idle(output int launches);
        launches = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (job_run) launches++;
            if (!busy && queue_count == 3'd0) break;
        end
        check("wait_idle_busy", {127'd0, busy}, 128'd0);
    endtask

    logic [31:0] jd;
    int          n, cyc, launches;
    int          t_launch[8];
    logic [63:0] l_launch[8];

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{64'h1000, 1'b0, 1'b1};
        vecs[1] = '{64'h0, 1'b1, 1'b0};
        vecs[2] = '{64'h41, 1'b1, 1'b0};
        vecs[3] = '{64'h40, 1'b0, 1'b1};
        vecs[4] = '{64'h20, 1'b1, 1'b0};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFC0, 1'b0, 1'b1};

        rst_n = 1'b0; desc_valid = 0; flush = 0; clr_err = 0; rd_done = 0; wr_done = 0;
        desc_src = '0; desc_dest = '0; desc_length = '0; desc_iv = '0;
        #12;
        check("rst_ready", {127'd0, desc_ready}, 128'd1);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_count", {125'd0, queue_count}, 128'd0);
        check("rst_jobs", {96'd0, jobs_done}, 128'd0);
        check("rst_len", {64'd0, job_length}, 128'd0);
        rst_n = 1'b1;
        step();

        // Single job: rd_done pulse at +10, wr_done level at +20.
        enq(64'h1000, 128'h1);
        check("sj_idle", {127'd0, job_run}, 128'd0);
        step();
        check("sj_run", {127'd0, job_run}, 128'd1);
        check("sj_len", {64'd0, job_length}, 128'h1000);
        check("sj_iv", job_iv, 128'h1);
        check("sj_src", {70'd0, job_src}, 128'h2);
        check("sj_cnt", {125'd0, queue_count}, 128'd0);
        step();
        check("sj_pulse", {127'd0, job_run}, 128'd0);
        repeat (8) step();
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        repeat (9) step();
        wr_done = 1'b1;
        step();
        check("sj_complete", {96'd0, jobs_done}, 128'd0);
        step();
        check("sj_jobs", {96'd0, jobs_done}, 128'd1);
        check("sj_busy", {127'd0, busy}, 128'd0);
        check("sj_to", {127'd0, err_timeout}, 128'd0);

        // Table: dones held high, so each launched job must still take exactly one WAIT cycle.
        rd_done = 1'b1; wr_done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            clr_err = 1'b1;
            step();
            clr_err = 1'b0;
            check("tv_clr", {127'd0, err_len}, 128'd0);
            jd = jobs_done;
            enq(vecs[i].len, 128'(i));
            check("tv_err", {127'd0, err_len}, {127'd0, vecs[i].exp_err});
            check("tv_cnt", {125'd0, queue_count}, {127'd0, vecs[i].exp_launch});
            step();
            check("tv_run", {127'd0, job_run}, {127'd0, vecs[i].exp_launch});
            if (vecs[i].exp_launch) begin
                check("tv_len", {64'd0, job_length}, {64'd0, vecs[i].len});
                repeat (3) step();
                check("tv_in_complete", {96'd0, jobs_done}, {96'd0, jd});
                step();
                check("tv_done", {96'd0, jobs_done}, {96'd0, jd + 32'd1});
                check("tv_busy", {127'd0, busy}, 128'd0);
            end else begin
                check("tv_nobusy", {127'd0, busy}, 128'd0);
                check("tv_nojob", {96'd0, jobs_done}, {96'd0, jd});
            end
        end

        // Error event wins over clr_err in the same cycle.
        clr_err = 1'b1;
        enq(64'h41, 128'h9);
        clr_err = 1'b0;
        check("clr_vs_err", {127'd0, err_len}, 128'd1);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        check("clr_after", {127'd0, err_len}, 128'd0);

        // Back-to-back: stall job A so four more fill the FIFO, then release.
        rd_done = 1'b0; wr_done = 1'b0;
        jd = jobs_done;
        enq(64'h40, 128'hA0);
        for (int k = 0; k < 4; k++) enq(64'h40 * (k + 2), 128'(k + 1));
        check("bb_full_cnt", {125'd0, queue_count}, 128'd4);
        desc_valid = 1'b1; desc_length = 64'h180; desc_iv = 128'h5;
        #1;
        check("bb_full_ready", {127'd0, desc_ready}, 128'd0);
        step();
        desc_valid = 1'b0;
        check("bb_held", {125'd0, queue_count}, 128'd4);
        rd_done = 1'b1; wr_done = 1'b1;
        n = 0; cyc = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            cyc++;
            if (job_run && n < 8) begin
                t_launch[n] = cyc;
                l_launch[n] = job_length;
                n++;
            end
            if (!busy && queue_count == 3'd0) break;
        end
        check("bb_launches", 128'(n), 128'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < n) check("bb_order", {64'd0, l_launch[k]}, 128'(64'h40 * (k + 2)));
            if (k > 0 && k < n) check("bb_spacing", 128'(t_launch[k] - t_launch[k-1]), 128'd4);
        end
        check("bb_jobs", {96'd0, jobs_done}, {96'd0, jd + 32'd5});

        // Watchdog: 100 WAIT cycles then abort, queued job still launches.
        rd_done = 1'b0; wr_done = 1'b0;
        jd = jobs_done;
        enq(64'h40, 128'h77);
        enq(64'h80, 128'h78);
        check("wd_run", {127'd0, job_run}, 128'd1);
        check("wd_len", {64'd0, job_length}, 128'h40);
        repeat (101) step();
        check("wd_not_yet", {127'd0, err_timeout}, 128'd0);
        check("wd_busy", {127'd0, busy}, 128'd1);
        step();
        check("wd_fired", {127'd0, err_timeout}, 128'd1);
        check("wd_idle", {127'd0, busy}, 128'd0);
        check("wd_jobs", {96'd0, jobs_done}, {96'd0, jd});
        step();
        check("wd_next_run", {127'd0, job_run}, 128'd1);
        check("wd_next_iv", job_iv, 128'h78);
        rd_done = 1'b1; wr_done = 1'b1;
        wait_idle(launches);
        check("wd_next_done", {96'd0, jobs_done}, {96'd0, jd + 32'd1});
        clr_err = 1'b1; step(); clr_err = 1'b0;
        check("wd_clr", {127'd0, err_timeout}, 128'd0);

        // Flush during WAIT drops the queue but not the in-flight job.
        rd_done = 1'b0; wr_done = 1'b0;
        jd = jobs_done;
        enq(64'h40, 128'hB0);
        enq(64'h80, 128'hB1);
        enq(64'hC0, 128'hB2);
        step();
        check("fl_cnt", {125'd0, queue_count}, 128'd2);
        flush = 1'b1;
        #1;
        check("fl_ready", {127'd0, desc_ready}, 128'd0);
        step();
        flush = 1'b0;
        check("fl_empty", {125'd0, queue_count}, 128'd0);
        check("fl_busy", {127'd0, busy}, 128'd1);
        rd_done = 1'b1; wr_done = 1'b1;
        wait_idle(launches);
        check("fl_no_launch", 128'(launches), 128'd0);
        check("fl_jobs", {96'd0, jobs_done}, {96'd0, jd + 32'd1});

        // Asynchronous reset mid-WAIT.
        rd_done = 1'b0; wr_done = 1'b0;
        enq(64'h41, 128'hC0);
        enq(64'h40, 128'hC1);
        enq(64'h80, 128'hC2);
        repeat (2) step();
        check("rs_busy", {127'd0, busy}, 128'd1);
        check("rs_err_set", {127'd0, err_len}, 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_busy0", {127'd0, busy}, 128'd0);
        check("rs_cnt0", {125'd0, queue_count}, 128'd0);
        check("rs_jobs0", {96'd0, jobs_done}, 128'd0);
        check("rs_len0", {64'd0, job_length}, 128'd0);
        check("rs_err0", {127'd0, err_len}, 128'd0);
        check("rs_ready1", {127'd0, desc_ready}, 128'd1);
        step();
        rst_n = 1'b1;
        launches = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (job_run) launches++;
        end
        check("rs_no_run", 128'(launches), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
